// File: rtl/io_uart_txq.sv
// Dual-lane UART transmit queue: lane a/b IO writes enqueue bytes in order (a then b),
// FWFT byte stream out to the emitter, busy status readable on both IO read buses.
module io_uart_txq #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          a_IO_mem_wr,
  input  logic [13:0]   a_IO_wordaddr,
  input  logic [31:0]   a_IO_mem_wdata,
  output logic [31:0]   a_IO_mem_rdata,
  input  logic          b_IO_mem_wr,
  input  logic [13:0]   b_IO_wordaddr,
  input  logic [31:0]   b_IO_mem_wdata,
  output logic [31:0]   b_IO_mem_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [LW-1:0] level,
  output logic          overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic          push_a, push_b;
  logic          acc_a, acc_b;
  logic          pop;
  logic          busy;
  logic [LW-1:0] free;
  logic [AW-1:0] wr_b_idx;

  assign push_a = a_IO_mem_wr & a_IO_wordaddr[1];
  assign push_b = b_IO_mem_wr & b_IO_wordaddr[1];

  // Space is judged on the pre-cycle level; a same-cycle pop never frees room for a push.
  assign free  = LW'(DEPTH) - level_q;
  assign acc_a = push_a && (free != '0);
  assign acc_b = push_b && (push_a ? (free >= LW'(2)) : (free != '0));
  assign busy  = free < LW'(2);

  assign tx_valid = (level_q != '0);
  assign pop      = tx_valid & tx_ready;
  assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = overflow_q;

  assign a_IO_mem_rdata = a_IO_wordaddr[2] ? {22'b0, busy, 9'b0} : '0;
  assign b_IO_mem_rdata = b_IO_wordaddr[2] ? {22'b0, busy, 9'b0} : '0;

  // Lane b lands directly behind lane a when both are accepted.
  assign wr_b_idx = wr_ptr_q + AW'(acc_a);

  always_comb begin
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(acc_a) + AW'(acc_b);
    level_d    = level_q + LW'(acc_a) + LW'(acc_b) - LW'(pop);
    overflow_d = overflow_q | (push_a & ~acc_a) | (push_b & ~acc_b);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_a) mem_q[wr_ptr_q] <= a_IO_mem_wdata[7:0];
    if (acc_b) mem_q[wr_b_idx] <= b_IO_mem_wdata[7:0];
  end

endmodule

// File: tb/tb_io_uart_txq.sv
// Bench for io_uart_txq: byte-queue reference model checked every cycle, plus directed literal checks.
module tb_io_uart_txq;

  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          a_wr = 1'b0, b_wr = 1'b0;
  logic [13:0]   a_addr = '0, b_addr = '0;
  logic [31:0]   a_wdata = '0, b_wdata = '0;
  logic [31:0]   a_rdata, b_rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [LW-1:0] level;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  io_uart_txq #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .resetn(resetn),
    .a_IO_mem_wr(a_wr), .a_IO_wordaddr(a_addr), .a_IO_mem_wdata(a_wdata), .a_IO_mem_rdata(a_rdata),
    .b_IO_mem_wr(b_wr), .b_IO_wordaddr(b_addr), .b_IO_mem_wdata(b_wdata), .b_IO_mem_rdata(b_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue as a list of bytes plus a sticky drop flag.
  logic [7:0] mq[$];
  logic       movf = 1'b0;
  int         mslots;
  logic       mpop;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      mslots = DEPTH - mq.size();
      mpop   = (mq.size() != 0) && tx_ready;
      if (mpop) void'(mq.pop_front());
      if (a_wr && a_addr[1]) begin
        if (mslots > 0) begin mq.push_back(a_wdata[7:0]); mslots--; end
        else movf = 1'b1;
      end
      if (b_wr && b_addr[1]) begin
        if (mslots > 0) begin mq.push_back(b_wdata[7:0]); mslots--; end
        else movf = 1'b1;
      end
    end
  end

  logic [7:0] cap[$];

  always @(negedge clk) begin
    logic        ev;
    logic [31:0] erd;
    if (resetn === 1'b1) begin
      ev  = (mq.size() != 0);
      erd = ((DEPTH - mq.size()) < 2) ? 32'h0000_0200 : 32'h0;
      chk("m_valid", tx_valid, ev);
      chk("m_data", tx_data, ev ? mq[0] : 8'h00);
      chk("m_level", level, mq.size());
      chk("m_overflow", overflow, movf);
      chk("m_rdata_a", a_rdata, a_addr[2] ? erd : 32'h0);
      chk("m_rdata_b", b_rdata, b_addr[2] ? erd : 32'h0);
      if (tx_valid && tx_ready) cap.push_back(tx_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
  endtask

  task automatic push(input logic wa, input logic [13:0] aa, input logic [7:0] da,
                      input logic wb, input logic [13:0] ab, input logic [7:0] db);
    a_wr = wa; a_addr = aa; a_wdata = {24'h5A5A5A, da};
    b_wr = wb; b_addr = ab; b_wdata = {24'hC3C3C3, db};
    cyc();
    a_wr = 1'b0; b_wr = 1'b0;
  endtask

  initial begin
    int found;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int found;
    do_reset();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 1'b0);

    // Single byte, ready held high: visible next cycle, gone the cycle after.
    tx_ready = 1'b1;
    push(1, 14'h0002, 8'h48, 0, 14'h0, 8'h00);
    chk("t1_valid", tx_valid, 1'b1);
    chk("t1_data", tx_data, 8'h48);
    chk("t1_level", level, 1);
    cyc();
    chk("t1_level_after", level, 0);
    chk("t1_valid_after", tx_valid, 1'b0);

    // Dual push, ordering a then b.
    tx_ready = 1'b0;
    push(1, 14'h0002, 8'h41, 1, 14'h0002, 8'h42);
    chk("t2_level", level, 2);
    chk("t2_head", tx_data, 8'h41);
    cap.delete();
    tx_ready = 1'b1;
    repeat (3) cyc();
    chk("t2_cnt", cap.size(), 2);
    chk("t2_b0", cap[0], 8'h41);
    chk("t2_b1", cap[1], 8'h42);
    tx_ready = 1'b0;

    // Fill to 15 (lane b writes to a non-push address and must be ignored), then overflow.
    do_reset();
    for (int i = 0; i < 14; i++) push(1, 14'h3FFA, 8'(8'h60 + i), 1, 14'h0001, 8'hEE);
    a_addr = 14'h0004; b_addr = 14'h0004; #1;
    chk("t3_rd14_a", a_rdata, 32'h0);
    chk("t3_rd14_b", b_rdata, 32'h0);
    push(1, 14'h0002, 8'h6E, 0, 14'h0, 8'h00);
    chk("t3_level15", level, 15);
    a_addr = 14'h0004; b_addr = 14'h0006; #1;
    chk("t3_rd15_a", a_rdata, 32'h0000_0200);
    chk("t3_rd15_b", b_rdata, 32'h0000_0200);
    a_addr = 14'h0000; b_addr = 14'h0000; #1;
    chk("t3_rd0_a", a_rdata, 32'h0);
    chk("t3_rd0_b", b_rdata, 32'h0);
    push(1, 14'h0002, 8'h10, 1, 14'h0002, 8'h11);
    chk("t3_level16", level, 16);
    chk("t3_overflow", overflow, 1'b1);
    cap.delete();
    tx_ready = 1'b1;
    repeat (18) cyc();
    chk("t3_cnt", cap.size(), 16);
    chk("t3_first", cap[0], 8'h60);
    chk("t3_last", cap[15], 8'h10);
    chk("t3_ovf_sticky", overflow, 1'b1);
    tx_ready = 1'b0;

    // Full queue: simultaneous pop and push drops the push.
    do_reset();
    for (int i = 0; i < 8; i++) push(1, 14'h0002, 8'(8'h80 + 2*i), 1, 14'h0002, 8'(8'h81 + 2*i));
    chk("t4_level16", level, 16);
    chk("t4_ovf0", overflow, 1'b0);
    cap.delete();
    tx_ready = 1'b1;
    push(1, 14'h0002, 8'h99, 0, 14'h0, 8'h00);
    chk("t4_level15", level, 15);
    chk("t4_ovf1", overflow, 1'b1);
    repeat (17) cyc();
    chk("t4_cnt", cap.size(), 16);
    found = 0;
    foreach (cap[i]) if (cap[i] == 8'h99) found++;
    chk("t4_no_99", found, 0);
    chk("t4_last", cap[15], 8'h8F);
    tx_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle discards everything at once.
    do_reset();
    for (int i = 0; i < 5; i++) push(1, 14'h0002, 8'(8'h30 + i), 0, 14'h0, 8'h00);
    chk("t5_level5", level, 5);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_valid", tx_valid, 1'b0);
    chk("t5_level", level, 0);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_data", tx_data, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    tx_ready = 1'b1;
    push(1, 14'h0002, 8'h55, 0, 14'h0, 8'h00);
    chk("t5_new_valid", tx_valid, 1'b1);
    chk("t5_new_data", tx_data, 8'h55);
    chk("t5_new_level", level, 1);
    cyc();
    chk("t5_drained", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_txq.md
Name: io_uart_txq

Overview:
Dual-lane UART transmit queue between the dual-issue core's two IO write ports (lane a, lane b) and the corescore_emitter_uart transmitter.
- Decodes UART-data writes from both lanes in one cycle and enqueues them in program order (a before b).
- Presents a first-word-fall-through byte stream to the emitter over valid/ready.
- Returns the UART status word on both IO read buses, so software polls queue space rather than the transmitter.

Parameters:
DEPTH, 16, queue capacity in bytes; power of two, minimum 4
LW, 5, level width; equals log2(DEPTH)+1

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
a_IO_mem_wr  in  1  lane a IO write strobe
a_IO_wordaddr  in  14  lane a IO word address
a_IO_mem_wdata  in  32  lane a IO write data
a_IO_mem_rdata  out  32  lane a IO read data
b_IO_mem_wr  in  1  lane b IO write strobe
b_IO_wordaddr  in  14  lane b IO word address
b_IO_mem_wdata  in  32  lane b IO write data
b_IO_mem_rdata  out  32  lane b IO read data
tx_data  out  8  byte to emitter (i_data)
tx_valid  out  1  byte available (i_valid)
tx_ready  in  1  emitter ready (o_ready)
level  out  LW  bytes currently queued
overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (async assert, sync release on clk): pointers=0, level=0, tx_valid=0, overflow=0, tx_data=0. Storage contents are don't-care.
- Push decode per lane: push_x = x_IO_mem_wr & x_IO_wordaddr[1]; byte = x_IO_mem_wdata[7:0]. The remaining address bits are ignored.
- Read data is combinational per lane:
  - x_IO_wordaddr[2]=1 gives {22'b0, busy, 9'b0}; otherwise 32'b0.
  - busy = (DEPTH - level) < 2, so software never overflows even when both lanes write in the same cycle.
- Pop: pop = tx_valid & tx_ready.
  - tx_valid = (level != 0).
  - tx_data = storage[rd_ptr], combinational from registered state; stable while tx_valid & !tx_ready.
- Free space: free = DEPTH - level, using the pre-cycle level. A same-cycle pop does not add space for a same-cycle push.
- Enqueue order: a then b.
  - Both pushes, free>=2: write a at wr_ptr, b at wr_ptr+1, wr_ptr += 2.
  - Both pushes, free==1: write a only, drop b, set overflow.
  - Both pushes, free==0: drop both, set overflow.
  - Single push: enqueue if free>=1, else drop and set overflow.
- Level update: level_next = level + accepted(0..2) - pop. Pointers wrap modulo DEPTH.
- Latency: a byte pushed into an empty queue gives tx_valid=1 and tx_data=byte in the next cycle.
- Push into an empty queue while pop=0 never bypasses storage.
- Simultaneous push and pop at level==DEPTH: pop proceeds and the push is dropped (free computed pre-pop). Level becomes DEPTH-1; overflow sets.
- overflow is cleared only by reset.
- Reset mid-transfer: queue contents are discarded immediately. tx_valid deasserts asynchronously; the emitter is reset by the same resetn.

Test Plan:
- Single lane a writes 0x48 to wordaddr 2, tx_ready=1 -> tx_valid high next cycle with tx_data=0x48; popped that cycle; level returns to 0.
- Same-cycle a=0x41 and b=0x42 with tx_ready=0 -> level=2; then raise tx_ready -> tx_data emits 0x41 then 0x42 in consecutive cycles.
- Fill to DEPTH-1=15 with tx_ready=0, then dual push 0x10/0x11 -> 0x10 accepted, level=16, overflow=1; drain yields 16 bytes ending with 0x10.
- Level=15: read wordaddr 4 on both lanes -> rdata=0x00000200. Level=14 -> rdata=0x00000000. Wordaddr 0 always returns 0.
- Full queue with pop and push in the same cycle -> level=15, pushed byte absent from drained stream, overflow=1.
- Push 5 bytes, assert resetn=0 asynchronously mid-cycle -> tx_valid=0, level=0 and overflow=0 immediately. After release, a new push of 0x55 emits first.
